// File: rtl/mole_game_core.sv
// Whack-a-mole engine: LFSR spawn, shrinking reaction window, score/miss tally.
// Ports: clk, rst_n (sync, active-low), ena, start, btn -> mole, score, misses, game_over, hit/miss pulses.
module mole_game_core #(
  parameter int NUM_MOLES      = 8,
  parameter int TICK_DIV       = 1000,
  parameter int TIMEOUT_MS     = 1000,
  parameter int MIN_TIMEOUT_MS = 250,
  parameter int SPEEDUP_MS     = 50,
  parameter int GAP_MS         = 200,
  parameter int MAX_MISSES     = 3,
  parameter int SCORE_W        = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ena,
  input  logic                              start,
  input  logic [NUM_MOLES-1:0]              btn,
  output logic [NUM_MOLES-1:0]              mole,
  output logic [SCORE_W-1:0]                score,
  output logic [$clog2(MAX_MISSES+1)-1:0]   misses,
  output logic                              game_over,
  output logic                              hit_pulse,
  output logic                              miss_pulse
);

  localparam int WW     = $clog2(TIMEOUT_MS + 1);
  localparam int MS_MAX = (TIMEOUT_MS > GAP_MS) ? TIMEOUT_MS : GAP_MS;
  localparam int CW     = $clog2(MS_MAX + 1);
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW     = $clog2(MAX_MISSES + 1);
  localparam int SPW    = ($clog2(SPEEDUP_MS + 1) > WW) ?
                          $clog2(SPEEDUP_MS + 1) : WW;
  localparam int SW     = SPW + 1;

  localparam logic [PW-1:0]      PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0]      WIN_INIT  = WW'(TIMEOUT_MS);
  localparam logic [WW-1:0]      WIN_MIN   = WW'(MIN_TIMEOUT_MS);
  localparam logic [CW-1:0]      GAP_LAST  = CW'(GAP_MS - 1);
  localparam logic [MW-1:0]      MISS_MAX  = MW'(MAX_MISSES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [15:0]        SEED      = 16'hACE1;
  localparam logic [3:0]         NM        = 4'(NUM_MOLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_UP,
    S_GAP,
    S_OVER
  } state_t;

  state_t                 r_state;
  logic [15:0]            r_lfsr;
  logic [NUM_MOLES-1:0]   r_btn_q;
  logic [PW-1:0]          r_pre;
  logic [CW-1:0]          r_ms;
  logic [WW-1:0]          r_window;
  logic [3:0]             r_prev_idx;
  logic                   r_prev_vld;
  logic [NUM_MOLES-1:0]   r_mole;
  logic [SCORE_W-1:0]     r_score;
  logic [MW-1:0]          r_misses;
  logic                   r_over;
  logic                   r_hit;
  logic                   r_miss;

  logic [15:0]            w_lfsr_shift;
  logic [15:0]            w_lfsr_nxt;
  logic [NUM_MOLES-1:0]   w_rise;
  logic                   w_wrong;
  logic                   w_good;
  logic                   w_tick;
  logic [CW-1:0]          w_win_m1;
  logic                   w_up_exp;
  logic                   w_gap_exp;
  logic [PW-1:0]          w_pre_nxt;
  logic [CW-1:0]          w_ms_nxt;
  logic [3:0]             w_idx_raw;
  logic [3:0]             w_idx_inc;
  logic [3:0]             w_idx;
  logic [NUM_MOLES-1:0]   w_mole_nxt;
  logic [SCORE_W-1:0]     w_score_inc;
  logic [MW-1:0]          w_miss_inc;
  logic [SW-1:0]          w_win_sub;
  logic                   w_win_clamp;
  logic [WW-1:0]          w_win_hit;

  // Fibonacci LFSR, taps 16,14,13,11; lock-up state is replaced by the seed
  assign w_lfsr_shift = {r_lfsr[14:0],
                         r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_lfsr_nxt   = (w_lfsr_shift == 16'h0) ? SEED : w_lfsr_shift;

  assign w_rise  = btn & ~r_btn_q;
  // any stray rise is a miss, even alongside the lit button
  assign w_wrong = |(w_rise & ~r_mole);
  assign w_good  = |(w_rise & r_mole);

  assign w_tick    = (r_pre == PRE_LAST);
  assign w_win_m1  = CW'(r_window) - CW'(1);
  assign w_up_exp  = w_tick && (r_ms == w_win_m1);
  assign w_gap_exp = w_tick && (r_ms == GAP_LAST);
  assign w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
  assign w_ms_nxt  = w_tick ? r_ms + CW'(1) : r_ms;

  // lane pick; a repeat of the previous lane is nudged to the next one
  assign w_idx_raw  = {1'b0, r_lfsr[2:0]} % NM;
  assign w_idx_inc  = (w_idx_raw == NM - 4'd1) ? 4'd0 : w_idx_raw + 4'd1;
  assign w_idx      = (r_prev_vld && (w_idx_raw == r_prev_idx)) ?
                      w_idx_inc : w_idx_raw;
  assign w_mole_nxt = NUM_MOLES'(1) << w_idx;

  assign w_score_inc = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
  assign w_miss_inc  = r_misses + MW'(1);

  // subtract in a wider field so a borrow is visible, then clamp
  assign w_win_sub   = SW'(r_window) - SW'(SPEEDUP_MS);
  assign w_win_clamp = w_win_sub[SW-1] || (w_win_sub < SW'(MIN_TIMEOUT_MS));
  assign w_win_hit   = w_win_clamp ? WIN_MIN : w_win_sub[WW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_btn_q    <= '0;
      r_pre      <= '0;
      r_ms       <= '0;
      r_window   <= WIN_INIT;
      r_prev_idx <= '0;
      r_prev_vld <= 1'b0;
      r_mole     <= '0;
      r_score    <= '0;
      r_misses   <= '0;
      r_over     <= 1'b0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
    end else if (ena) begin
      r_lfsr  <= w_lfsr_nxt;
      r_btn_q <= btn;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_prev_vld <= 1'b0;
            r_state    <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          r_mole     <= w_mole_nxt;
          r_prev_idx <= w_idx;
          r_prev_vld <= 1'b1;
          r_pre      <= '0;
          r_ms       <= '0;
          r_state    <= S_UP;
        end
        S_UP: begin
          if (w_wrong || (!w_good && w_up_exp)) begin
            r_misses <= w_miss_inc;
            r_miss   <= 1'b1;
            r_mole   <= '0;
            r_pre    <= '0;
            r_ms     <= '0;
            if (w_miss_inc == MISS_MAX) begin
              r_over  <= 1'b1;
              r_state <= S_OVER;
            end else begin
              r_state <= S_GAP;
            end
          end else if (w_good) begin
            r_score  <= w_score_inc;
            r_window <= w_win_hit;
            r_hit    <= 1'b1;
            r_mole   <= '0;
            r_pre    <= '0;
            r_ms     <= '0;
            r_state  <= S_GAP;
          end else begin
            r_pre <= w_pre_nxt;
            r_ms  <= w_ms_nxt;
          end
        end
        S_GAP: begin
          if (w_gap_exp) begin
            r_state <= S_SPAWN;
          end else begin
            r_pre <= w_pre_nxt;
            r_ms  <= w_ms_nxt;
          end
        end
        S_OVER: begin
          if (start) begin
            r_score    <= '0;
            r_misses   <= '0;
            r_window   <= WIN_INIT;
            r_over     <= 1'b0;
            r_prev_vld <= 1'b0;
            r_state    <= S_SPAWN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mole       = r_mole;
  assign score      = r_score;
  assign misses     = r_misses;
  assign game_over  = r_over;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;

endmodule

// File: tb/tb_mole_game_core.sv
// Testbench for mole_game_core: table of game events plus freeze,
// reset and spawn-sequence scenarios.
module tb_mole_game_core;

  localparam int NM  = 4;
  localparam int MMX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          start;
  logic [NM-1:0] btn;
  logic [NM-1:0] mole;
  logic [7:0]    score;
  logic [1:0]    misses;
  logic          game_over;
  logic          hit_pulse;
  logic          miss_pulse;

  always #5 clk = ~clk;

  mole_game_core #(
    .NUM_MOLES(NM), .TICK_DIV(4), .TIMEOUT_MS(5), .MIN_TIMEOUT_MS(2),
    .SPEEDUP_MS(1), .GAP_MS(2), .MAX_MISSES(MMX), .SCORE_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .btn(btn),
    .mole(mole), .score(score), .misses(misses), .game_over(game_over),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  int checks = 0;
  int errors = 0;

  // reference LFSR; m_lfsr_d is the value held during the previous cycle
  logic [15:0] m_lfsr;
  logic [15:0] m_lfsr_d;

  function automatic logic [15:0] lnext(input logic [15:0] v);
    logic [15:0] n;
    n = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    if (n == 16'h0) n = 16'hACE1;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
    end else if (ena) begin
      m_lfsr_d <= m_lfsr;
      m_lfsr   <= lnext(m_lfsr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_mole(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mole != '0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_mole: got no lit mole, expected one within 200 cycles");
    end
  endtask

  // counts remaining lit cycles, pressing per act/p; returns total lit
  task automatic run_lit(input int act, input int p, inout int len);
    for (int k = 0; k < 500; k++) begin
      if (act == 1 && len == p) btn = mole;
      if (act == 2 && len == p) btn = mole | {mole[0], mole[NM-1:1]};
      step();
      if (mole == '0) break;
      len++;
    end
  endtask

  typedef struct {
    int act;
    int p;
    bit hold;
    bit restart;
    int len;
    bit hit;
    bit miss;
    int score;
    int misses;
    bit over;
  } vec_t;

  localparam int NV = 10;
  vec_t tv [NV];

  bit          ok;
  int          len;
  logic [NM-1:0] saved;
  bit          bad;
  int          idx;
  int          pidx;
  bit          pv;
  logic [NM-1:0] prevm;
  int          lane_cnt [NM];

  initial begin
    // act: 0 timeout, 1 press lit lane at lit-cycle p, 2 lit+neighbour at p
    tv[0] = '{1,  1, 0, 1,  1, 1, 0, 1, 0, 0};
    tv[1] = '{0,  0, 0, 0, 16, 0, 1, 1, 1, 0};
    tv[2] = '{1, 16, 0, 0, 16, 1, 0, 2, 1, 0};
    tv[3] = '{0,  0, 0, 0, 12, 0, 1, 2, 2, 0};
    tv[4] = '{1, 12, 0, 0, 12, 1, 0, 3, 2, 0};
    tv[5] = '{1,  8, 0, 0,  8, 1, 0, 4, 2, 0};
    tv[6] = '{0,  0, 0, 0,  8, 0, 1, 4, 3, 1};
    tv[7] = '{0,  0, 0, 1, 20, 0, 1, 0, 1, 0};
    tv[8] = '{2,  3, 1, 0,  3, 0, 1, 0, 2, 0};
    tv[9] = '{0,  0, 0, 0, 20, 0, 1, 0, 3, 1};

    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    btn   = '0;
    step();
    step();
    chk("reset_outputs",
        32'({mole, score, misses, game_over, hit_pulse, miss_pulse}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_outputs",
          32'({mole, score, misses, game_over, hit_pulse, miss_pulse}), 32'd0);
    end

    for (int r = 0; r < NV; r++) begin
      if (tv[r].restart) pulse_start();
      wait_mole(ok);
      len = 1;
      run_lit(tv[r].act, tv[r].p, len);
      chk($sformatf("v%0d_lit_len", r), 32'(len), 32'(tv[r].len));
      chk($sformatf("v%0d_hit", r), 32'(hit_pulse), 32'(tv[r].hit));
      chk($sformatf("v%0d_miss", r), 32'(miss_pulse), 32'(tv[r].miss));
      chk($sformatf("v%0d_score", r), 32'(score), 32'(tv[r].score));
      chk($sformatf("v%0d_misses", r), 32'(misses), 32'(tv[r].misses));
      chk($sformatf("v%0d_over", r), 32'(game_over), 32'(tv[r].over));
      if (!tv[r].hold) btn = '0;
      step();
      chk($sformatf("v%0d_pulse_1cyc", r),
          32'({hit_pulse, miss_pulse}), 32'd0);
    end

    // freeze mid-UP, then the window resumes where it stopped
    pulse_start();
    wait_mole(ok);
    len = 1;
    saved = mole;
    while (len < 5) begin
      step();
      len++;
    end
    ena = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (mole !== saved || hit_pulse || miss_pulse) bad = 1'b1;
    end
    chk("freeze_hold", 32'(bad), 32'd0);
    ena = 1'b1;
    run_lit(0, 0, len);
    chk("freeze_lit_len", 32'(len), 32'd20);
    chk("freeze_miss", 32'(miss_pulse), 32'd1);
    chk("freeze_misses", 32'(misses), 32'd1);

    // reset in the middle of a lit window
    wait_mole(ok);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("midreset_outputs",
        32'({mole, score, misses, game_over, hit_pulse, miss_pulse}), 32'd0);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mole != '0) bad = 1'b1;
    end
    chk("midreset_idle", 32'(bad), 32'd0);

    // spawn sequence against the reference LFSR, with saturation at 255
    for (int i = 0; i < NM; i++) lane_cnt[i] = 0;
    pv = 1'b0;
    pidx = 0;
    prevm = '0;
    pulse_start();
    for (int s = 0; s < 260; s++) begin
      wait_mole(ok);
      if (!ok) break;
      idx = int'(m_lfsr_d[2:0]) % NM;
      if (pv && idx == pidx) idx = (idx + 1) % NM;
      chk("spawn_lane", 32'(mole), 32'(1 << idx));
      if (pv) chk("spawn_no_repeat", 32'(mole == prevm), 32'd0);
      for (int b = 0; b < NM; b++) if (mole[b]) lane_cnt[b]++;
      prevm = mole;
      pidx = idx;
      pv = 1'b1;
      btn = mole;
      step();
      chk("spawn_hit", 32'(hit_pulse), 32'd1);
      btn = '0;
    end
    chk("score_saturate", 32'(score), 32'd255);
    chk("spawn_misses", 32'(misses), 32'd0);
    for (int b = 0; b < NM; b++)
      chk($sformatf("lane%0d_seen", b), 32'(lane_cnt[b] > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
